// File: rtl/xoodyak_msg_packer.sv
// xoodyak_msg_packer: packs message beats into RATE_BYTES blocks, MSB-first; define XOODYAK_PAD_EN to insert the 0x01 pad byte.
module xoodyak_msg_packer #(
  parameter int BUS_BYTES  = 1,
  parameter int RATE_BYTES = 16,
  parameter int LEN_W      = 12
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [LEN_W-1:0]                 msg_len,
  input  logic [8*BUS_BYTES-1:0]           msg_data,
  input  logic                             msg_valid,
  output logic                             msg_ready,
  output logic [8*RATE_BYTES-1:0]          blk_data,
  output logic [$clog2(RATE_BYTES+1)-1:0]  blk_bytes,
  output logic                             blk_last,
  output logic                             blk_valid,
  input  logic                             blk_ready,
  output logic                             busy
);
  localparam int CW = $clog2(RATE_BYTES+1);
  localparam int TW = $clog2(BUS_BYTES+1);
  localparam int BW = 8*RATE_BYTES;
`ifdef XOODYAK_PAD_EN
  localparam logic [BW-1:0] EMPTY_BLK = {8'h01, {(BW-8){1'b0}}};
`else
  localparam logic [BW-1:0] EMPTY_BLK = '0;
`endif
  typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;
  state_t           state;
  logic [LEN_W-1:0] remaining, rem_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic [TW-1:0]    take;
  logic [BW-1:0]    fill_nxt;
  always_comb begin
    take     = (remaining >= LEN_W'(BUS_BYTES)) ? TW'(BUS_BYTES) : TW'(remaining);
    rem_nxt  = remaining - LEN_W'(take);
    cnt_nxt  = blk_bytes + CW'(take);
    fill_nxt = blk_data;
    for (int p = 0; p < RATE_BYTES; p++) begin
      for (int i = 0; i < BUS_BYTES; i++)
        if (i < int'(take) && p == int'(blk_bytes) + i)
          fill_nxt[BW-1-8*p -: 8] = msg_data[8*BUS_BYTES-1-8*i -: 8];
`ifdef XOODYAK_PAD_EN
      // a short block can only occur on the final beat, so the pad follows the last byte
      if (rem_nxt == '0 && p == int'(cnt_nxt))
        fill_nxt[BW-1-8*p -: 8] = 8'h01;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      blk_bytes <= '0;
      blk_data  <= '0;
      blk_last  <= 1'b0;
      blk_valid <= 1'b0;
      msg_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          remaining <= msg_len;
          blk_bytes <= '0;
          busy      <= 1'b1;
          if (msg_len == '0) begin
            blk_data  <= EMPTY_BLK;
            blk_last  <= 1'b1;
            blk_valid <= 1'b1;
            state     <= EMIT;
          end else begin
            blk_data  <= '0;
            blk_last  <= 1'b0;
            msg_ready <= 1'b1;
            state     <= FILL;
          end
        end
        FILL: if (msg_valid && msg_ready) begin
          remaining <= rem_nxt;
          blk_bytes <= cnt_nxt;
          blk_data  <= fill_nxt;
          if (cnt_nxt == CW'(RATE_BYTES) || rem_nxt == '0) begin
            blk_last  <= (rem_nxt == '0);
            blk_valid <= 1'b1;
            msg_ready <= 1'b0;
            state     <= EMIT;
          end
        end
        EMIT: if (blk_ready) begin
          blk_valid <= 1'b0;
          if (blk_last) begin
            blk_last <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            blk_data  <= '0;
            blk_bytes <= '0;
            msg_ready <= 1'b1;
            state     <= FILL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xoodyak_msg_packer.sv
// tb_xoodyak_msg_packer: scoreboard bench driving a 1-byte-bus and a 4-byte-bus packer with directed messages.
module tb_xoodyak_msg_packer;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic s1 = 0, v1 = 0, br1 = 1, r1, bl1, bv1, busy1;
  logic [11:0] len1 = '0;
  logic [7:0] d1 = '0;
  logic [127:0] bd1;
  logic [4:0] bb1;
  logic s4 = 0, v4 = 0, br4 = 1, r4, bl4, bv4, busy4;
  logic [11:0] len4 = '0;
  logic [31:0] d4 = '0;
  logic [127:0] bd4;
  logic [4:0] bb4;
  xoodyak_msg_packer #(.BUS_BYTES(1), .RATE_BYTES(16), .LEN_W(12)) u1 (
    .clk(clk), .reset(reset), .start(s1), .msg_len(len1), .msg_data(d1), .msg_valid(v1),
    .msg_ready(r1), .blk_data(bd1), .blk_bytes(bb1), .blk_last(bl1), .blk_valid(bv1),
    .blk_ready(br1), .busy(busy1));
  xoodyak_msg_packer #(.BUS_BYTES(4), .RATE_BYTES(16), .LEN_W(12)) u4 (
    .clk(clk), .reset(reset), .start(s4), .msg_len(len4), .msg_data(d4), .msg_valid(v4),
    .msg_ready(r4), .blk_data(bd4), .blk_bytes(bb4), .blk_last(bl4), .blk_valid(bv4),
    .blk_ready(br4), .busy(busy4));
  typedef struct {logic [127:0] d; logic [4:0] b; logic l;} exp_t;
  exp_t q1[$], q4[$];
  exp_t e1, e4;
  int total = 0, passed = 0, acc4 = 0;
  logic [7:0] msg [64];
  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic tmo(string nm);
    total++;
    $display("FAIL %s: timed out", nm);
  endtask
  function automatic logic [127:0] build(int off, int n);
    logic [127:0] d = '0;
    for (int i = 0; i < n; i++) d[127-8*i -: 8] = msg[off+i];
`ifdef XOODYAK_PAD_EN
    if (n < 16) d[127-8*n -: 8] = 8'h01;
`endif
    return d;
  endfunction
  task automatic push(int w, int len);
    exp_t e;
    int k = 0;
    int n;
    do begin
      n = (len - 16*k > 16) ? 16 : len - 16*k;
      e.d = build(16*k, n);
      e.b = 5'(n);
      e.l = (16*(k+1) >= len);
      if (w == 1) q1.push_back(e); else q4.push_back(e);
      k++;
    end while (16*k < len);
  endtask
  always @(negedge clk) if (!reset && bv1 && br1) begin
    if (q1.size() == 0) begin
      total++;
      $display("FAIL u1 extra block: got bytes %0d expected none", bb1);
    end else begin
      e1 = q1.pop_front();
      chk("u1 blk_data", bd1, e1.d);
      chk("u1 blk_bytes", 128'(bb1), 128'(e1.b));
      chk("u1 blk_last", 128'(bl1), 128'(e1.l));
    end
  end
  always @(negedge clk) if (!reset && bv4 && br4) begin
    if (q4.size() == 0) begin
      total++;
      $display("FAIL u4 extra block: got bytes %0d expected none", bb4);
    end else begin
      e4 = q4.pop_front();
      chk("u4 blk_data", bd4, e4.d);
      chk("u4 blk_bytes", 128'(bb4), 128'(e4.b));
      chk("u4 blk_last", 128'(bl4), 128'(e4.l));
    end
  end
  always @(negedge clk) if (!reset && v4 && r4) acc4++;
  task automatic start_msg(int w, int len);
    if (w == 1) begin s1 = 1; len1 = 12'(len); end
    else begin s4 = 1; len4 = 12'(len); end
    @(posedge clk); #1;
    s1 = 0; s4 = 0;
  endtask
  task automatic feed1(logic [7:0] b);
    int t = 0;
    d1 = b; v1 = 1;
    @(negedge clk);
    while (!r1 && t < 50) begin @(negedge clk); t++; end
    if (!r1) tmo("u1 msg_ready");
    @(posedge clk); #1;
    v1 = 0;
  endtask
  task automatic feed4(logic [31:0] b);
    int t = 0;
    d4 = b; v4 = 1;
    @(negedge clk);
    while (!r4 && t < 50) begin @(negedge clk); t++; end
    if (!r4) tmo("u4 msg_ready");
    @(posedge clk); #1;
    v4 = 0;
  endtask
  task automatic drain(int w);
    int t = 0;
    while (((w == 1) ? (q1.size() != 0 || busy1) : (q4.size() != 0 || busy4)) && t < 200) begin
      @(posedge clk); t++;
    end
    if (t == 200) tmo(w == 1 ? "u1 drain" : "u4 drain");
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "bench timeout");
  end
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst u1 msg_ready", 128'(r1), 0);
    chk("rst u1 blk_valid", 128'(bv1), 0);
    chk("rst u1 blk_last", 128'(bl1), 0);
    chk("rst u1 blk_bytes", 128'(bb1), 0);
    chk("rst u1 blk_data", bd1, 0);
    chk("rst u1 busy", 128'(busy1), 0);
    chk("rst u4 msg_ready", 128'(r4), 0);
    chk("rst u4 blk_valid", 128'(bv4), 0);
    chk("rst u4 blk_data", bd4, 0);
    chk("rst u4 busy", 128'(busy4), 0);
    @(posedge clk); #1;
    reset = 0;
    // empty message: a single block with no data bytes
    push(1, 0); start_msg(1, 0); drain(1);
    // 19 bytes: one full block then a 3-byte last block
    for (int i = 0; i < 19; i++) msg[i] = 8'(i);
    push(1, 19); start_msg(1, 19);
    for (int i = 0; i < 19; i++) feed1(msg[i]);
    drain(1);
    // consumer stalls for 10 cycles; a start in the window must be ignored
    br1 = 0;
    msg[0] = 8'hA1; msg[1] = 8'hA2; msg[2] = 8'hA3;
    push(1, 3); start_msg(1, 3);
    for (int i = 0; i < 3; i++) feed1(msg[i]);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("u1 stall blk_valid", 128'(bv1), 1);
      chk("u1 stall blk_data", bd1, build(0, 3));
      chk("u1 stall msg_ready", 128'(r1), 0);
      if (c == 3) begin s1 = 1; len1 = 12'd5; end
      if (c == 4) s1 = 0;
    end
    br1 = 1;
    drain(1);
    repeat (5) @(negedge clk);
    chk("u1 start ignored busy", 128'(busy1), 0);
    // reset after 7 of 19 bytes abandons the message
    for (int i = 0; i < 19; i++) msg[i] = 8'(i);
    start_msg(1, 19);
    for (int i = 0; i < 7; i++) feed1(msg[i]);
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst busy", 128'(busy1), 0);
    chk("midrst msg_ready", 128'(r1), 0);
    chk("midrst blk_valid", 128'(bv1), 0);
    chk("midrst blk_last", 128'(bl1), 0);
    chk("midrst blk_bytes", 128'(bb1), 0);
    chk("midrst blk_data", bd1, 0);
    reset = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("postrst busy", 128'(busy1), 0);
    msg[0] = 8'h5A;
    push(1, 1); start_msg(1, 1); feed1(8'h5A); drain(1);
    // 4-byte bus: 16 bytes in exactly 4 beats, one block
    for (int i = 0; i < 16; i++) msg[i] = 8'(i);
    acc4 = 0;
    push(4, 16); start_msg(4, 16);
    for (int b = 0; b < 4; b++) feed4({msg[4*b], msg[4*b+1], msg[4*b+2], msg[4*b+3]});
    drain(4);
    chk("u4 beats accepted", 128'(acc4), 4);
    // 5 bytes: unused lanes of the last beat must be dropped
    for (int i = 0; i < 5; i++) msg[i] = 8'(i);
    push(4, 5); start_msg(4, 5);
    feed4(32'h00010203); feed4(32'h04AABBCC);
    drain(4);
    push(4, 0); start_msg(4, 0); drain(4);
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/xoodyak_msg_packer.md
XOODYAK_MSG_PACKER -- requirements
Module: xoodyak_msg_packer

Interface
REQ-001 SHALL have parameter BUS_BYTES, default 1: message bytes per input beat; legal values 1, 2, 4.
REQ-002 SHALL have parameter RATE_BYTES, default 16: block size in bytes; must be a multiple of BUS_BYTES.
REQ-003 SHALL have parameter LEN_W, default 12: width of the message length in bytes.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: one-cycle pulse that begins a message; msg_len is sampled on the same edge.
REQ-007 SHALL have port msg_len, input, LEN_W: message length in bytes.
REQ-008 SHALL have port msg_data, input, 8*BUS_BYTES: message beat; the first byte is in the MSB lane.
REQ-009 SHALL have port msg_valid, input, 1: msg_data holds valid bytes.
REQ-010 SHALL have port msg_ready, output, 1: the block accepts a beat this cycle.
REQ-011 SHALL have port blk_data, output, 8*RATE_BYTES: packed block; the first byte is in bits [8*RATE_BYTES-1 -: 8].
REQ-012 SHALL have port blk_bytes, output, $clog2(RATE_BYTES+1): count of message bytes in the block.
REQ-013 SHALL have port blk_last, output, 1: this is the final block of the message.
REQ-014 SHALL have port blk_valid, output, 1: the block is presented.
REQ-015 SHALL have port blk_ready, input, 1: the consumer takes the block.
REQ-016 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-017 SHALL implement the states IDLE, FILL and EMIT.
REQ-018 SHALL ignore start unless in IDLE.
REQ-019 SHALL, on start in IDLE, load remaining <= msg_len, clear the block register and byte counter, and enter FILL; if msg_len==0 it SHALL enter EMIT instead, with blk_bytes=0 and blk_last=1.
REQ-020 SHALL drive msg_ready=1 only in FILL.
REQ-021 SHALL treat a beat as accepted on msg_valid&&msg_ready.
REQ-022 SHALL, on an accepted beat, consume min(BUS_BYTES, remaining) bytes from the MSB lanes and ignore the remaining lanes.
REQ-023 SHALL write the consumed bytes at the block byte counter position and add the consumed count to the counter.
REQ-024 SHALL enter EMIT on the edge where the block fills or remaining reaches 0; blk_last=1 iff remaining==0.
REQ-025 SHALL hold blk_valid=1 and keep blk_data, blk_bytes and blk_last stable in EMIT until blk_valid&&blk_ready.
REQ-026 SHALL, on that handshake, go to IDLE if blk_last, else clear the block register and return to FILL.
REQ-027 SHALL zero all block bytes at or above blk_bytes, except the pad byte defined in REQ-033.
REQ-028 SHALL emit exactly max(1, ceil(msg_len/RATE_BYTES)) blocks per message; a length that is an exact multiple of RATE_BYTES SHALL produce no extra block.
REQ-029 SHALL have a latency of 1 cycle from the edge of the last accepted beat of a block to blk_valid=1.
REQ-030 SHALL be able to accept a beat in the first FILL cycle after an EMIT handshake; no bubble other than the EMIT cycle itself.

Reset
REQ-031 SHALL, while reset=1, enter IDLE on the next edge and drive msg_ready=0, blk_valid=0, blk_last=0, blk_bytes=0, blk_data=0, busy=0; all internal counters SHALL be 0.
REQ-032 SHALL, on reset asserted mid-message (FILL or EMIT), abandon the message; after deassertion no block is emitted until a new start.

Configuration
REQ-033 SHALL, when the macro XOODYAK_PAD_EN is defined, write byte 0x01 at position blk_bytes of every block whose blk_bytes<RATE_BYTES; a full block carries no pad byte. With the macro undefined, no pad byte is written (the core pads) and all unused bytes are 0.

Verification
REQ-034 SHALL be checked with BUS_BYTES=1, RATE=16: start with msg_len=0 -> one block, blk_bytes=0, blk_last=1; blk_data=0 (0x01 in the top byte with XOODYAK_PAD_EN).
REQ-035 SHALL be checked with BUS_BYTES=1: msg_len=19, bytes 0x00..0x12 -> block 1 = 0x00..0x0F, bytes 16, last 0; block 2 = 0x10..0x12, bytes 3, last 1.
REQ-036 SHALL be checked with BUS_BYTES=4: msg_len=16 -> exactly 4 beats accepted, one block with bytes 16 and last 1, and no extra block.
REQ-037 SHALL be checked with BUS_BYTES=4: msg_len=5, beats 0x00010203 then 0x04AABBCC -> blk_bytes=5; bytes 0xAA..0xCC do not appear in blk_data.
REQ-038 SHALL be checked: blk_ready held low for 10 cycles in EMIT -> blk_valid and blk_data stable, msg_ready=0, and a start pulse in that window is ignored.
REQ-039 SHALL be checked: reset pulsed after 7 of 19 bytes -> busy=0 and all outputs 0; a new msg_len=1 message then yields one correct block.
